// File: rtl/univ_shift_reg_param_if.sv
// univ_shift_reg_param_if: request/status bundle for the universal shift register
interface univ_shift_reg_param_if #(
    parameter int WIDTH = 8,
    parameter int AMT_W = 3
);
    logic             start;
    logic [2:0]       mode;
    logic [AMT_W-1:0] amt;
    logic             sin;
    logic [WIDTH-1:0] data;
    logic [WIDTH-1:0] dout;
    logic             sout;
    logic             busy;
    logic             done;
    modport master (output start, mode, amt, sin, data, input dout, sout, busy, done);
    modport slave (input start, mode, amt, sin, data, output dout, sout, busy, done);
endinterface

// File: rtl/univ_shift_reg_param.sv
// univ_shift_reg_param: width-parametrised universal shift register, one shift step per clock
module univ_shift_reg_param #(
    parameter int WIDTH = 8,
    parameter int AMT_W = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    univ_shift_reg_param_if.slave bus
);
    typedef enum logic {IDLE, SHIFT} state_t;
    typedef enum logic [2:0] {NOP, LOAD, SRL, SLL, ROR, ROL, ASR, CLR} mode_t;
    state_t           state;
    mode_t            mode_q;
    mode_t            cur_mode;
    logic [AMT_W-1:0] cnt;
    logic [WIDTH-1:0] dout_q;
    logic [WIDTH-1:0] nxt;
    logic             nxt_out;
    logic             sout_q;
    logic             busy_q;
    logic             done_q;
    logic             is_shift;
    // while idle the incoming mode drives the first step, afterwards the latched one
    always_comb begin
        cur_mode = state == SHIFT ? mode_q : mode_t'(bus.mode);
        is_shift = cur_mode inside {SRL, SLL, ROR, ROL, ASR};
        nxt_out  = (cur_mode == SLL || cur_mode == ROL) ? dout_q[WIDTH-1] : dout_q[0];
        nxt      = cur_mode == SRL ? {bus.sin, dout_q[WIDTH-1:1]} :
                   cur_mode == SLL ? {dout_q[WIDTH-2:0], bus.sin} :
                   cur_mode == ROR ? {dout_q[0], dout_q[WIDTH-1:1]} :
                   cur_mode == ROL ? {dout_q[WIDTH-2:0], dout_q[WIDTH-1]} :
                   cur_mode == ASR ? {dout_q[WIDTH-1], dout_q[WIDTH-1:1]} : dout_q;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            mode_q <= NOP;
            cnt    <= '0;
            dout_q <= '0;
            sout_q <= 1'b0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (state == IDLE) begin
                if (bus.start) begin
                    mode_q <= cur_mode;
                    if (cur_mode == LOAD)
                        dout_q <= bus.data;
                    else if (cur_mode == CLR)
                        dout_q <= '0;
                    else if (is_shift && bus.amt != '0) begin
                        dout_q <= nxt;
                        sout_q <= nxt_out;
                    end
                    if (is_shift && bus.amt > AMT_W'(1)) begin
                        state  <= SHIFT;
                        busy_q <= 1'b1;
                        cnt    <= bus.amt - 1'b1;
                    end else
                        done_q <= 1'b1;
                end
            end else begin
                dout_q <= nxt;
                sout_q <= nxt_out;
                cnt    <= cnt - 1'b1;
                if (cnt == AMT_W'(1)) begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                    done_q <= 1'b1;
                end
            end
        end
    end
    assign bus.dout = dout_q;
    assign bus.sout = sout_q;
    assign bus.busy = busy_q;
    assign bus.done = done_q;
endmodule
